// File: rtl/overload_detector.sv
// overload_detector: windowed magnitude-threshold detector with hysteresis that
// drives the agc overload flag. Measurement is blanked for a fixed settle time
// after enable and after every agc gain step.
module overload_detector #(
    parameter int WINDOW_LEN      = 16,
    parameter int THRESH          = 7,
    parameter int HIT_COUNT       = 3,
    parameter int RELEASE_WINDOWS = 2,
    parameter int SETTLE_CYC      = 4
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       en,
    input  logic       sample_valid,
    input  logic [3:0] amplified_signal,
    input  logic       gain_change,
    output logic       overload,
    output logic [3:0] peak_out,
    output logic       window_done
);

    localparam int WIN_W = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
    localparam int HIT_W = $clog2(HIT_COUNT + 1);

    localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(WINDOW_LEN - 1);
    localparam logic [HIT_W-1:0] HIT_MAX     = HIT_W'(HIT_COUNT);
    localparam logic [3:0]       THRESH_V    = 4'(THRESH);
    localparam logic [3:0]       RELEASE_V   = 4'(RELEASE_WINDOWS);
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       settle_cnt_q, settle_cnt_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [3:0]       win_peak_q, win_peak_d;
    logic [3:0]       clean_cnt_q, clean_cnt_d;
    logic             overload_q, overload_d;
    logic [3:0]       peak_q, peak_d;
    logic             window_done_q, window_done_d;

    logic [3:0]       mag;
    logic             is_hit;
    logic [3:0]       peak_next;
    logic [HIT_W-1:0] hit_next;
    logic [3:0]       clean_next;

    // Per-sample datapath: magnitude (-8 maps to 8), hit test, running peak and hit count.
    always_comb begin
        mag        = amplified_signal[3] ? (~amplified_signal + 4'd1) : amplified_signal;
        is_hit     = (mag >= THRESH_V);
        peak_next  = (mag > win_peak_q) ? mag : win_peak_q;
        hit_next   = (is_hit && (hit_cnt_q != HIT_MAX)) ? (hit_cnt_q + HIT_W'(1)) : hit_cnt_q;
        clean_next = clean_cnt_q + 4'd1;
    end

    // Next-state and output decode; en=0 beats gain_change, which beats window end.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        win_cnt_d     = win_cnt_q;
        hit_cnt_d     = hit_cnt_q;
        win_peak_d    = win_peak_q;
        clean_cnt_d   = clean_cnt_q;
        overload_d    = overload_q;
        peak_d        = peak_q;
        window_done_d = 1'b0;

        if (!en) begin
            state_d      = IDLE;
            settle_cnt_d = '0;
            win_cnt_d    = '0;
            hit_cnt_d    = '0;
            win_peak_d   = '0;
            clean_cnt_d  = '0;
            overload_d   = 1'b0;
        end else if (gain_change) begin
            // Gain just moved: the in-flight window is meaningless, drop it and re-settle.
            state_d      = SETTLE;
            settle_cnt_d = '0;
            win_cnt_d    = '0;
            hit_cnt_d    = '0;
            win_peak_d   = '0;
            clean_cnt_d  = '0;
            overload_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d      = SETTLE;
                    settle_cnt_d = '0;
                end
                SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d    = MEASURE;
                        win_cnt_d  = '0;
                        hit_cnt_d  = '0;
                        win_peak_d = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 8'd1;
                    end
                end
                MEASURE: begin
                    if (sample_valid) begin
                        if (win_cnt_q == WIN_LAST) begin
                            // Window closes on this sample; next window starts with the next one.
                            window_done_d = 1'b1;
                            peak_d        = peak_next;
                            win_cnt_d     = '0;
                            hit_cnt_d     = '0;
                            win_peak_d    = '0;
                            if (hit_next == HIT_MAX) begin
                                overload_d  = 1'b1;
                                clean_cnt_d = '0;
                            end else if (clean_next >= RELEASE_V) begin
                                overload_d  = 1'b0;
                                clean_cnt_d = '0;
                            end else begin
                                clean_cnt_d = clean_next;
                            end
                        end else begin
                            win_cnt_d  = win_cnt_q + WIN_W'(1);
                            hit_cnt_d  = hit_next;
                            win_peak_d = peak_next;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (RESET) begin
            state_q       <= IDLE;
            settle_cnt_q  <= '0;
            win_cnt_q     <= '0;
            hit_cnt_q     <= '0;
            win_peak_q    <= '0;
            clean_cnt_q   <= '0;
            overload_q    <= 1'b0;
            peak_q        <= '0;
            window_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            win_cnt_q     <= win_cnt_d;
            hit_cnt_q     <= hit_cnt_d;
            win_peak_q    <= win_peak_d;
            clean_cnt_q   <= clean_cnt_d;
            overload_q    <= overload_d;
            peak_q        <= peak_d;
            window_done_q <= window_done_d;
        end
    end

    assign overload    = overload_q;
    assign peak_out    = peak_q;
    assign window_done = window_done_q;

endmodule

// File: tb/tb_overload_detector.sv
// Self-checking bench for overload_detector: directed scenarios followed by
// randomized traffic, scored against a window-level behavioural model.
module tb_overload_detector;

    localparam int WL = 16;
    localparam int TH = 7;
    localparam int HC = 3;
    localparam int RW = 2;
    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       en = 1'b0;
    logic       sample_valid = 1'b0;
    logic [3:0] amplified_signal = 4'd0;
    logic       gain_change = 1'b0;
    logic       overload;
    logic [3:0] peak_out;
    logic       window_done;

    overload_detector #(
        .WINDOW_LEN(WL), .THRESH(TH), .HIT_COUNT(HC),
        .RELEASE_WINDOWS(RW), .SETTLE_CYC(SC)
    ) dut (
        .clk(clk), .RESET(RESET), .en(en), .sample_valid(sample_valid),
        .amplified_signal(amplified_signal), .gain_change(gain_change),
        .overload(overload), .peak_out(peak_out), .window_done(window_done)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        int peak;
        int ovl;
    } exp_t;
    exp_t exp_q[$];

    // Behavioural reference: explicit list of the current window's magnitudes.
    int m_active      = 0;   // 0: idle, 1: enabled (settling or measuring)
    int m_settle_left = 0;   // blank cycles still to go before measuring
    int m_ovl         = 0;
    int m_peak        = 0;
    int m_clean       = 0;
    int m_win[$];

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    function automatic int mag_of(input logic [3:0] s);
        int v;
        v = int'($signed(s));
        return (v < 0) ? -v : v;
    endfunction

    function automatic void close_window();
        int hits = 0;
        int pk   = 0;
        foreach (m_win[i]) begin
            if (m_win[i] >= TH) hits++;
            if (m_win[i] > pk)  pk = m_win[i];
        end
        m_peak = pk;
        if (hits >= HC) begin
            m_ovl   = 1;
            m_clean = 0;
        end else begin
            m_clean++;
            if (m_clean >= RW) begin
                m_ovl   = 0;
                m_clean = 0;
            end
        end
        exp_q.push_back('{peak: m_peak, ovl: m_ovl});
        m_win.delete();
    endfunction

    function automatic void model_update(input logic r, input logic e, input logic v,
                                         input logic [3:0] s, input logic g);
        if (r) begin
            m_active = 0; m_ovl = 0; m_peak = 0; m_clean = 0; m_win.delete();
        end else if (!e) begin
            m_active = 0; m_ovl = 0; m_clean = 0; m_win.delete();
        end else if (g) begin
            m_active = 1; m_settle_left = SC; m_ovl = 0; m_clean = 0; m_win.delete();
        end else if (m_active == 0) begin
            m_active = 1; m_settle_left = SC;
        end else if (m_settle_left > 0) begin
            m_settle_left--;
            if (m_settle_left == 0) m_win.delete();
        end else if (v) begin
            m_win.push_back(mag_of(s));
            if (m_win.size() == WL) close_window();
        end
    endfunction

    // One clock of stimulus; inputs change 1 time unit after the active edge.
    task automatic step(input logic r, input logic e, input logic v,
                        input logic [3:0] s, input logic g);
        RESET = r; en = e; sample_valid = v; amplified_signal = s; gain_change = g;
        @(posedge clk);
        model_update(r, e, v, s, g);
        #1;
    endtask

    task automatic send(input logic [3:0] s);
        step(1'b0, 1'b1, 1'b1, s, 1'b0);
    endtask

    task automatic settle();
        repeat (SC) step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic zero_window();
        repeat (WL) send(4'd0);
    endtask

    task automatic hit_window();
        for (int i = 0; i < WL; i++) send((i % 4 == 1) ? 4'd7 : 4'd2);
    endtask

    // Monitor: compare registered outputs each cycle; pop the scoreboard on window_done.
    always @(negedge clk) begin
        exp_t e;
        check("overload", int'(overload), m_ovl);
        check("peak_out", int'(peak_out), m_peak);
        if (window_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_window_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("window_peak", int'(peak_out), e.peak);
                check("window_overload", int'(overload), e.ovl);
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("missing_window_done", int'(window_done), 1);
        end
    end

    initial begin
        // 1: reset, enable, settle, one all-zero window.
        repeat (3) step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        settle();
        zero_window();

        // 2: -8, 7, 7 at positions 2, 5, 9 -> overload, peak 8.
        for (int i = 1; i <= WL; i++)
            send((i == 2) ? 4'b1000 : ((i == 5 || i == 9) ? 4'd7 : 4'd0));

        // 3: two 7s and one -6, rest 1 -> only 2 hits, peak 7.
        for (int i = 1; i <= WL; i++)
            send((i == 3 || i == 11) ? 4'd7 : ((i == 6) ? 4'b1010 : 4'd1));

        // 4: hysteresis: arm, clean, re-arm, clean, clean.
        hit_window();
        zero_window();
        hit_window();
        zero_window();
        zero_window();

        // 5: gain_change at valid sample 10 with overload set, then at sample 16.
        hit_window();
        for (int i = 1; i <= 9; i++) send(4'd7);
        step(1'b0, 1'b1, 1'b1, 4'd7, 1'b1);
        settle();
        hit_window();
        for (int i = 1; i <= WL - 1; i++) send(4'd7);
        step(1'b0, 1'b1, 1'b1, 4'd7, 1'b1);
        settle();

        // 6a: sample_valid toggling every other cycle.
        for (int i = 0; i < 2 * WL; i++)
            step(1'b0, 1'b1, logic'(i % 2), (i % 6 == 1) ? 4'b1001 : 4'd3, 1'b0);

        // 6b: RESET at sample 8.
        hit_window();
        for (int i = 1; i <= 7; i++) send(4'd5);
        step(1'b1, 1'b1, 1'b1, 4'd5, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        settle();

        // 6c: en=0 mid-window with overload set; peak_out must hold.
        hit_window();
        for (int i = 1; i <= 6; i++) send(4'd6);
        step(1'b0, 1'b0, 1'b1, 4'd7, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        settle();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            logic r, e, v, g;
            logic [3:0] s;
            r = ($urandom_range(599) == 0);
            e = ($urandom_range(299) != 0);
            g = ($urandom_range(199) == 0);
            v = ($urandom_range(9) < 7);
            s = 4'($urandom_range(15));
            step(r, e, v, s, g);
        end

        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/overload_detector.md
Name: overload_detector

Overview:
- Generates the `overload` flag consumed by the agc loop, replacing the behavioural gain-vs-target model with a synthesizable detector.
- Watches the 4-bit two's-complement `amplified_signal` samples from the VGA/ADC front end over fixed windows.
- Asserts `overload` when too many samples reach a magnitude threshold, and releases it with hysteresis.
- Blanks measurement while the signal settles after each agc gain step.

Parameters:
- WINDOW_LEN, 16: valid samples per measurement window; legal range 2..256.
- THRESH, 7: magnitude at or above which a sample counts as a hit; legal range 1..8.
- HIT_COUNT, 3: hits in one window needed to declare overload; legal range 1..WINDOW_LEN.
- RELEASE_WINDOWS, 2: consecutive clean windows needed to deassert overload; legal range 1..15.
- SETTLE_CYC, 4: clk cycles blanked after enable or gain_change; legal range 1..255.

Ports:
- clk  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- en  input  1  detector enable.
- sample_valid  input  1  amplified_signal carries a new sample this cycle.
- amplified_signal  input  4  two's-complement sample from the front end.
- gain_change  input  1  one-cycle pulse from agc when the gain code has just changed.
- overload  output  1  registered overload flag to agc.
- peak_out  output  4  peak magnitude (0..8) of the last completed window.
- window_done  output  1  one-cycle pulse when a window completes.

Behaviour:
- Reset (synchronous, RESET=1 at posedge):
  - state=IDLE; overload=0, peak_out=0, window_done=0.
  - All counters cleared. Reset overrides every other input.
- Magnitude: mag = |amplified_signal|, 4-bit unsigned. 4'b1000 (-8) maps to 8; no saturation. A sample is a hit iff mag >= THRESH.
- States:
  - IDLE: stays while en=0. en=1 -> SETTLE with settle_cnt cleared.
  - SETTLE: counts SETTLE_CYC cycles, then -> MEASURE with win_cnt, hit_cnt and win_peak cleared. Samples are ignored.
  - MEASURE: on each sample_valid, win_cnt+1, hit_cnt+1 if hit (saturates at HIT_COUNT), win_peak=max(win_peak,mag). Cycles without sample_valid change nothing; windows count valid samples, not cycles.
- Window end, on the cycle that accepts the WINDOW_LEN-th valid sample. At the next posedge:
  - window_done=1 for exactly one cycle.
  - peak_out = final win_peak, including that last sample.
  - If hit_cnt (including last sample) >= HIT_COUNT: overload=1, clean_cnt=0.
  - Otherwise clean_cnt+1 (saturating). When clean_cnt reaches RELEASE_WINDOWS, overload=0 and clean_cnt=0.
  - Window counters clear and the next window starts immediately; no sample is dropped at the boundary.
- Latency: overload, peak_out and window_done change 1 cycle after the last sample of a window is presented.
- gain_change=1 while en=1, in any state:
  - Next cycle: overload=0, clean_cnt=0, the current window is aborted (no window_done, peak_out unchanged).
  - -> SETTLE with settle_cnt restarted. A gain_change during SETTLE restarts the settle count.
- en=0 in any state:
  - Next cycle: IDLE, overload=0, window and clean counters cleared, no window_done. peak_out holds.
- Precedence at the same posedge: RESET > en=0 > gain_change > window end. If gain_change coincides with the WINDOW_LEN-th sample, the window is discarded and no overload update occurs.
- overload only changes at window end, gain_change, en=0 or RESET. It never glitches within a window.

Test Plan:
1. Reset, en=1 with defaults; then 16 valid zero samples.
   - MEASURE entered 4 cycles after en rises.
   - window_done pulses 1 cycle after the 16th sample; overload=0, peak_out=0.
2. Window with samples -8, 7, 7 at positions 2, 5, 9, rest 0.
   - overload=1 one cycle after the 16th sample; peak_out=8.
3. Window with two samples of 7 and one of -6, rest 1.
   - overload stays 0 (only 2 hits); peak_out=7.
4. From overload=1, feed two all-zero windows.
   - overload still 1 after the first window_done; drops to 0 with the second.
   - A hit window between the two clean windows re-arms and holds overload=1.
5. gain_change at valid sample 10 with overload=1.
   - overload=0 and no window_done next cycle; 4 blank cycles.
   - The new window needs a full 16 valid samples.
   - Repeat with gain_change coincident with the 16th sample: again no window_done.
6. Gap and reset handling:
   - sample_valid toggling 50%: window_done occurs only after 16 valid samples (about 32 cycles).
   - RESET at sample 8: all outputs 0 next cycle, state IDLE.
   - en=0 mid-window: overload=0 and peak_out unchanged.
